// File: rtl/spi_master_link.sv
// spi_master_link: SPI mode-0 master that shifts push-bus words out on MOSI
// and hands the MISO word captured in the same frame downstream.
module spi_master_link #(
  parameter int WORD_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] tData,
  input  logic                  tRequest,
  output logic                  tDone,
  output logic [WORD_WIDTH-1:0] rData,
  output logic                  rRequest,
  input  logic                  rDone,
  output logic                  isBusy,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  nCS
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(2 * WORD_WIDTH + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DELIVER, GAP} state_t;
  state_t r_state, w_next;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic [GW-1:0] r_gap;
  logic [WORD_WIDTH-1:0] r_tx, r_rx, r_rdata;
  logic r_sck, r_ncs, r_tdone, r_rreq;
  logic w_tick, w_last, w_gap_end, w_timed;
  assign w_tick    = r_div == DW'(CLK_DIV - 1);
  assign w_last    = r_bit == BW'(2 * WORD_WIDTH - 1);
  assign w_gap_end = r_gap == GW'(CS_GAP - 1);
  assign w_timed   = r_state inside {SETUP, SHIFT, HOLD};
  assign tDone     = r_tdone;
  assign rData     = r_rdata;
  assign rRequest  = r_rreq;
  assign isBusy    = r_state != IDLE;
  assign sck       = r_sck;
  assign mosi      = r_tx[WORD_WIDTH-1];
  assign nCS       = r_ncs;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = tRequest ? SETUP : IDLE;
      SETUP:   w_next = w_tick ? SHIFT : SETUP;
      SHIFT:   w_next = (w_tick && w_last) ? HOLD : SHIFT;
      HOLD:    w_next = w_tick ? DELIVER : HOLD;
      DELIVER: w_next = rDone ? GAP : DELIVER;
      GAP:     w_next = w_gap_end ? IDLE : GAP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_sck   <= 1'b0;
      r_ncs   <= 1'b1;
      r_tdone <= 1'b0;
      r_rreq  <= 1'b0;
    end else begin
      r_tdone <= r_state == IDLE && tRequest;
      r_div   <= (w_timed && !w_tick) ? r_div + 1'b1 : '0;
      r_gap   <= r_state == GAP ? r_gap + 1'b1 : '0;
      case (r_state)
        IDLE: if (tRequest) begin
          r_tx  <= tData;
          r_ncs <= 1'b0;
        end
        SETUP: if (w_tick) begin
          r_sck <= 1'b1;
          r_bit <= '0;
          r_rx  <= {r_rx[WORD_WIDTH-2:0], miso};
        end
        // r_bit is the index of the half-period just ending; odd ones are low, so a rise follows
        SHIFT: if (w_tick && !w_last) begin
          r_sck <= ~r_sck;
          r_bit <= r_bit + 1'b1;
          if (r_bit[0]) r_rx <= {r_rx[WORD_WIDTH-2:0], miso};
          else if (r_bit != BW'(2 * WORD_WIDTH - 2)) r_tx <= {r_tx[WORD_WIDTH-2:0], 1'b0};
        end
        HOLD: if (w_tick) begin
          r_ncs   <= 1'b1;
          r_rdata <= r_rx;
          r_rreq  <= 1'b1;
        end
        DELIVER: if (rDone) r_rreq <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
